// File: rtl/accel_pkg.sv
// Shared opcode encodings, FSM state type and default operand width for the
// accelerator register file and its sequential execution stage.
package accel_pkg;

  localparam int unsigned DefaultWidth = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_REM = 3'b111;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StMulRun = 2'b01,
    StDivRun = 2'b10
  } state_e;

endpackage

// File: rtl/accel_seq_alu.sv
// Sequential execution stage: single-cycle ALU ops, shift-add multiply and
// restoring divide sharing one counter and a 2*WIDTH working register.
module accel_seq_alu
  import accel_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o
);

  localparam int unsigned RW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             rem_q, rem_d;
  logic [RW-1:0]    result_q, result_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;

  logic [RW-1:0]    a_ext, b_ext;
  logic             last_iter;
  logic             is_div_op;
  logic             b_zero;

  assign a_ext     = {{WIDTH{1'b0}}, a_i};
  assign b_ext     = {{WIDTH{1'b0}}, b_i};
  assign last_iter = (cnt_q == CntW'(1));
  assign is_div_op = (op_i == OP_DIV) || (op_i == OP_REM);
  assign b_zero    = (b_i == '0);

  // Multiply step: conditionally add A into the upper half, shift right with carry.
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [RW-1:0]    mul_acc;

  assign mul_addend = b_q[0] ? a_q : '0;
  assign mul_sum    = {1'b0, acc_q[RW-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_acc    = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: acc holds {remainder, quotient}; dividend bits shift in from a_q MSB.
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [RW-1:0]    div_acc;

  assign div_trial = {acc_q[RW-1:WIDTH], a_q[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, b_q};
  assign div_ge    = (div_trial >= {1'b0, b_q});
  assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_acc   = {div_rem, acc_q[WIDTH-2:0], div_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (op_i == OP_MUL) begin
            state_d = StMulRun;
          end else if (is_div_op && !b_zero) begin
            state_d = StDivRun;
          end
        end
      end
      StMulRun, StDivRun: begin
        if (last_iter) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o     = (state_q != StIdle);
    done_o     = done_q;
    result_o   = result_q;
    div_zero_o = div_zero_q;
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          unique case (op_i)
            OP_ADD: begin
              result_d   = a_ext + b_ext;
              div_zero_d = 1'b0;
              done_d     = 1'b1;
            end
            OP_SUB: begin
              result_d   = a_ext - b_ext;
              div_zero_d = 1'b0;
              done_d     = 1'b1;
            end
            OP_AND: begin
              result_d   = a_ext & b_ext;
              div_zero_d = 1'b0;
              done_d     = 1'b1;
            end
            OP_OR: begin
              result_d   = a_ext | b_ext;
              div_zero_d = 1'b0;
              done_d     = 1'b1;
            end
            OP_XOR: begin
              result_d   = a_ext ^ b_ext;
              div_zero_d = 1'b0;
              done_d     = 1'b1;
            end
            OP_MUL: begin
              a_d   = a_i;
              b_d   = b_i;
              acc_d = '0;
              cnt_d = CntW'(WIDTH);
              rem_d = 1'b0;
            end
            OP_DIV, OP_REM: begin
              if (b_zero) begin
                result_d   = (op_i == OP_DIV) ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : a_ext;
                div_zero_d = 1'b1;
                done_d     = 1'b1;
              end else begin
                a_d   = a_i;
                b_d   = b_i;
                acc_d = '0;
                cnt_d = CntW'(WIDTH);
                rem_d = (op_i == OP_REM);
              end
            end
          endcase
        end
      end
      StMulRun: begin
        acc_d = mul_acc;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CntW'(1);
        if (last_iter) begin
          result_d   = mul_acc;
          div_zero_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      StDivRun: begin
        acc_d = div_acc;
        a_d   = a_q << 1;
        cnt_d = cnt_q - CntW'(1);
        if (last_iter) begin
          result_d   = rem_q ? {{WIDTH{1'b0}}, div_acc[RW-1:WIDTH]} : div_acc;
          div_zero_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

endmodule
